// File: rtl/vec_acc_ctrl.sv
// Frame accumulator: reduces each beat with a combinational adder tree, then sums n_blocks beats.
// Define VEC_ACC_PIPE_EN to register the tree sum ahead of the accumulator (adds S_FLUSH).

module vec_sum_i8 #(
  parameter int unsigned bit_width = 8,
  parameter int unsigned length    = 32
) (
  input  logic signed [bit_width-1:0]                vec [length],
  output logic signed [bit_width+$clog2(length)-1:0] sum
);
  localparam int unsigned levels    = $clog2(length);
  localparam int unsigned sum_width = bit_width + levels;
  typedef logic signed [sum_width-1:0] word_t;

  // Level l holds length>>l partial sums; every level is sum_width wide so no adder can overflow.
  for (genvar l = 0; l <= levels; l++) begin : g_lvl
    word_t node [length >> l];
    for (genvar i = 0; i < (length >> l); i++) begin : g_node
      if (l == 0) begin : g_leaf
        assign node[i] = word_t'(vec[i]);
      end else begin : g_add
        assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
      end
    end
  end

  assign sum = g_lvl[levels].node[0];
endmodule

module vec_acc_ctrl #(
  parameter int unsigned bit_width = 8,
  parameter int unsigned length    = 32,
  parameter int unsigned n_blocks  = 4,
  parameter int unsigned acc_width = bit_width + $clog2(length) + $clog2(n_blocks)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic signed [bit_width-1:0] i_vec [length],
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [acc_width-1:0] o_sum
);
  localparam int unsigned sum_width = bit_width + $clog2(length);
  localparam int unsigned cnt_width = (n_blocks > 1) ? $clog2(n_blocks) : 1;
  localparam logic [cnt_width-1:0] last_cnt = cnt_width'(n_blocks - 1);

  typedef logic signed [acc_width-1:0] acc_t;
  typedef logic [cnt_width-1:0]        cnt_t;

`ifdef VEC_ACC_PIPE_EN
  typedef enum logic [1:0] {S_ACC, S_OUT, S_FLUSH} state_e;
  localparam state_e s_done = S_FLUSH;
`else
  typedef enum logic [1:0] {S_ACC, S_OUT} state_e;
  localparam state_e s_done = S_OUT;
`endif

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  acc_t   acc_q, acc_d;
  logic   rdy_q;
  logic   accept;
  logic   first_beat;
  logic   last_accept;

  logic signed [sum_width-1:0] tree_sum;
  acc_t                        tree_ext;

  vec_sum_i8 #(
    .bit_width(bit_width),
    .length   (length)
  ) u_tree (
    .vec(i_vec),
    .sum(tree_sum)
  );

  assign tree_ext = acc_t'(tree_sum);

`ifdef VEC_ACC_PIPE_EN
  acc_t pipe_sum_q;
  logic pipe_vld_q;
  logic pipe_first_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    o_valid = 1'b0;
    o_ready = 1'b0;

    unique case (state_q)
      S_ACC:   o_ready = rdy_q;
      S_OUT: begin
        o_valid = 1'b1;
        o_ready = i_ready;
      end
      default: o_ready = 1'b0;
    endcase

    accept      = i_valid & o_ready;
    // cnt is zero both at frame start and during S_OUT, so a handoff beat opens the next frame.
    first_beat  = (cnt_q == '0);
    last_accept = accept && (cnt_q == last_cnt);

    if (accept) begin
      cnt_d = last_accept ? '0 : cnt_q + 1'b1;
    end

`ifdef VEC_ACC_PIPE_EN
    if (pipe_vld_q) begin
      acc_d = pipe_first_q ? pipe_sum_q : acc_q + pipe_sum_q;
    end
`else
    if (accept) begin
      acc_d = first_beat ? tree_ext : acc_q + tree_ext;
    end
`endif

    unique case (state_q)
      S_ACC: begin
        if (last_accept) state_d = s_done;
      end
      S_OUT: begin
        if (i_ready) state_d = last_accept ? s_done : S_ACC;
      end
      default: state_d = S_OUT;
    endcase
  end

  assign o_sum = acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rdy_q   <= 1'b1;
    end
  end

`ifdef VEC_ACC_PIPE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_sum_q   <= '0;
      pipe_vld_q   <= 1'b0;
      pipe_first_q <= 1'b0;
    end else begin
      pipe_vld_q <= accept;
      if (accept) begin
        pipe_sum_q   <= tree_ext;
        pipe_first_q <= first_beat;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vec_acc_ctrl.sv
// Directed and randomized bench for vec_acc_ctrl; frame sums come from a plain-arithmetic model.
module tb_vec_acc_ctrl;
  localparam int BW  = 8;
  localparam int LEN = 32;
  localparam int NB  = 4;
  localparam int AW  = 15;
`ifdef VEC_ACC_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_valid, i_ready, o_ready, o_valid;
  logic signed [BW-1:0] i_vec [LEN];
  logic signed [AW-1:0] o_sum;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int frame_acc = 0;
  int frame_beats = 0;
  int frames_pushed = 0;
  int results = 0;
  bit rnd_ready = 1'b0;

  always #5 clk = ~clk;

  vec_acc_ctrl #(
    .bit_width(BW),
    .length   (LEN),
    .n_blocks (NB),
    .acc_width(AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_vec  (i_vec),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_sum  (o_sum)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int vec_total();
    int s = 0;
    for (int i = 0; i < LEN; i++) s += int'(i_vec[i]);
    return s;
  endfunction

  task automatic fill_const(input int v);
    for (int i = 0; i < LEN; i++) i_vec[i] = BW'(v);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < LEN; i++) i_vec[i] = BW'($urandom_range(0, 255));
  endtask

  // Offer the current i_vec until accepted; returns #1 after the accepting edge.
  task automatic send_beat();
    int budget = 0;
    i_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (o_ready) break;
      @(posedge clk);
      #1;
      if (rnd_ready) i_ready = ($urandom_range(0, 3) != 0);
      budget++;
      if (budget > 200) begin
        chk("accept_timeout", 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "FAIL accept_timeout: beat never accepted");
      end
    end
    @(posedge clk);
    frame_acc += vec_total();
    frame_beats++;
    if (frame_beats == NB) begin
      exp_q.push_back(frame_acc);
      frames_pushed++;
      frame_acc   = 0;
      frame_beats = 0;
    end
    #1;
    i_valid = 1'b0;
  endtask

  task automatic frame_const(input int v);
    fill_const(v);
    repeat (NB) send_beat();
  endtask

  // Leaves the caller at a falling edge where o_valid should be high.
  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("result_valid_seen", o_valid, 1);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    i_valid = 1'b0;
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_sum", o_sum, 0);
    chk("rst_o_ready", o_ready, 0);
    exp_q.delete();
    frame_acc   = 0;
    frame_beats = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("ready_low_until_edge", o_ready, 0);
    @(posedge clk);
    #1;
    chk("ready_after_first_edge", o_ready, 1);
  endtask

  // Every handoff must match the oldest completed frame of the model.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      results++;
      chk("result_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("frame_sum", o_sum, exp_q.pop_front());
    end
  end

  initial begin
    i_valid = 1'b0;
    i_ready = 1'b1;
    fill_const(0);
    #2;
    do_reset();

    // All ones, back-to-back; check result latency and single-cycle pulse.
    frame_const(1);
    for (int k = 1; k <= LAT; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      chk("latency_valid", o_valid, (k == LAT));
    end
    chk("sum_ones", o_sum, 128);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("valid_one_cycle", o_valid, 0);
    @(posedge clk);
    #1;

    // Full-scale extremes.
    frame_const(-128);
    wait_valid();
    chk("sum_min", o_sum, -16384);
    @(posedge clk);
    #1;
    frame_const(127);
    wait_valid();
    chk("sum_max", o_sum, 16256);
    @(posedge clk);
    #1;

    // Back-pressure: result must hold while i_ready is low.
    i_ready = 1'b0;
    frame_const(1);
    wait_valid();
    chk("stall_sum", o_sum, 128);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("stall_valid", o_valid, 1);
      chk("stall_sum_hold", o_sum, 128);
      chk("stall_ready_low", o_ready, 0);
    end
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    #1;
    chk("ready_follows_i_ready", o_ready, 1);
    chk("valid_at_handoff", o_valid, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("valid_cleared", o_valid, 0);
    @(posedge clk);
    #1;

    // Overlap: first beat of next frame accepted in the handoff cycle.
    i_ready = 1'b0;
    frame_const(1);
    wait_valid();
    @(posedge clk);
    #1;
    fill_const(2);
    i_ready = 1'b1;
    send_beat();
    @(negedge clk);
    chk("overlap_handoff_done", o_valid, 0);
    @(posedge clk);
    #1;
    fill_const(1);
    repeat (NB - 1) send_beat();
    wait_valid();
    chk("sum_overlap", o_sum, 160);
    @(posedge clk);
    #1;

    // Reset mid-frame discards the partial sum.
    fill_const(1);
    repeat (2) send_beat();
    do_reset();
    frame_const(3);
    wait_valid();
    chk("sum_after_rst", o_sum, 384);
    @(posedge clk);
    #1;

    // Long idle mid-frame.
    fill_const(5);
    repeat (2) send_beat();
    repeat (10) @(posedge clk);
    #1;
    fill_const(-7);
    repeat (2) send_beat();

    // Randomized frames with gaps and random back-pressure.
    rnd_ready = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      for (int b = 0; b < NB; b++) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
        fill_rand();
        send_beat();
      end
    end

    rnd_ready = 1'b0;
    i_ready   = 1'b1;
    for (int n = 0; n < 30 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("result_count", results, frames_pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
